// File: rtl/mp3_mem_pkg.sv
// Shared memory-subsystem definitions: ROM geometry, arbiter defaults and the
// return-pipeline payload type used by the ROM arbiter and its sub-modules.
package mp3_mem_pkg;

    localparam int ROM_DEPTH = 4096;
    localparam int ROM_WIDTH = 16;

    localparam int AW_DEF  = 12;
    localparam int DW_DEF  = 16;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } ret_t;

    // Out-of-range latencies are pinned to the nearest legal value.
    function automatic int clamp_lat(input int lat);
        if (lat < LAT_MIN) return LAT_MIN;
        if (lat > LAT_MAX) return LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/rom_ret_pipe.sv
// Return pipeline: delays each issued read's {valid, id} tag by LAT cycles so
// it lines up with the ROM output. Asynchronously cleared.
module rom_ret_pipe
    import mp3_mem_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic CLK,
    input  logic RST,
    input  ret_t din,
    output ret_t dout
);

    localparam int DEPTH = clamp_lat(LAT);

    ret_t stage [DEPTH];

    // NOTE: every stage is reset, not just the first, so reads in flight at
    // reset can never surface as a late rvalid once reset is released.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a single-port block ROM
// (blk_mem_gen_0); read data is shared and qualified by per-port rvalid.
module rom_arbiter
    import mp3_mem_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_dout
);

    req_id_e       last_gnt;
    logic [AW-1:0] addr_hold;
    ret_t          ret_in;
    ret_t          ret_out;

    // NOTE: defaults first so no path leaves a grant unassigned (no latch).
    // Ties go to the port not granted last; reset holds both grants low.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST) begin
            if (req0 && (!req1 || last_gnt == REQ_1)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign rom_en   = gnt0 | gnt1;
    assign rom_addr = gnt0 ? addr0 : (gnt1 ? addr1 : addr_hold);

    // NOTE: non-blocking assignments for all clocked state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_gnt  <= REQ_1;
            addr_hold <= '0;
        end else begin
            if (gnt0) begin
                last_gnt <= REQ_0;
            end else if (gnt1) begin
                last_gnt <= REQ_1;
            end
            addr_hold <= rom_addr;
        end
    end

    assign ret_in = '{valid: rom_en, id: req_id_e'(gnt1)};

    rom_ret_pipe #(
        .LAT (LAT)
    ) u_ret_pipe (
        .CLK  (CLK),
        .RST  (RST),
        .din  (ret_in),
        .dout (ret_out)
    );

    assign rvalid0 = ret_out.valid && (ret_out.id == REQ_0);
    assign rvalid1 = ret_out.valid && (ret_out.id == REQ_1);
    assign rdata   = rom_dout;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: a LAT=1 instance driven from a vector
// table and a LAT=3 instance for latency/ordering, plus a mid-cycle reset.
module tb_rom_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    function automatic logic [15:0] rom_word(input logic [11:0] a);
        return {4'h0, a} ^ 16'hA5A5;
    endfunction

    // LAT=1 instance
    logic        d1_req0 = 1'b0, d1_req1 = 1'b0;
    logic [11:0] d1_addr0 = '0, d1_addr1 = '0;
    logic        d1_gnt0, d1_gnt1, d1_rvalid0, d1_rvalid1, d1_rom_en;
    logic [15:0] d1_rdata, d1_rom_dout;
    logic [11:0] d1_rom_addr;
    logic [15:0] d1_rom_q;

    rom_arbiter #(.AW(12), .DW(16), .LAT(1)) dut1 (
        .CLK(CLK), .RST(RST),
        .req0(d1_req0), .addr0(d1_addr0), .gnt0(d1_gnt0), .rvalid0(d1_rvalid0),
        .req1(d1_req1), .addr1(d1_addr1), .gnt1(d1_gnt1), .rvalid1(d1_rvalid1),
        .rdata(d1_rdata), .rom_en(d1_rom_en), .rom_addr(d1_rom_addr),
        .rom_dout(d1_rom_dout)
    );

    always @(posedge CLK) if (d1_rom_en) d1_rom_q <= rom_word(d1_rom_addr);
    assign d1_rom_dout = d1_rom_q;

    // LAT=3 instance
    logic        d3_req0 = 1'b0, d3_req1 = 1'b0;
    logic [11:0] d3_addr0 = '0, d3_addr1 = '0;
    logic        d3_gnt0, d3_gnt1, d3_rvalid0, d3_rvalid1, d3_rom_en;
    logic [15:0] d3_rdata, d3_rom_dout;
    logic [11:0] d3_rom_addr;
    logic [15:0] d3_pipe [3];

    rom_arbiter #(.AW(12), .DW(16), .LAT(3)) dut3 (
        .CLK(CLK), .RST(RST),
        .req0(d3_req0), .addr0(d3_addr0), .gnt0(d3_gnt0), .rvalid0(d3_rvalid0),
        .req1(d3_req1), .addr1(d3_addr1), .gnt1(d3_gnt1), .rvalid1(d3_rvalid1),
        .rdata(d3_rdata), .rom_en(d3_rom_en), .rom_addr(d3_rom_addr),
        .rom_dout(d3_rom_dout)
    );

    always @(posedge CLK) begin
        if (d3_rom_en) d3_pipe[0] <= rom_word(d3_rom_addr);
        d3_pipe[1] <= d3_pipe[0];
        d3_pipe[2] <= d3_pipe[1];
    end
    assign d3_rom_dout = d3_pipe[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        req0;
        logic [11:0] addr0;
        logic        req1;
        logic [11:0] addr1;
        logic        gnt0;
        logic        gnt1;
        logic [11:0] rom_addr;
        logic        rv0;
        logic        rv1;
        logic [15:0] rdata;
    } vec_t;

    typedef struct {
        logic        req0;
        logic [11:0] addr0;
        logic        req1;
        logic [11:0] addr1;
        int          gid;   // expected grant: 0, 1, or -1 for none
    } bvec_t;

    vec_t  vecs [19];
    bvec_t bursts [10];

    initial begin
        vecs[0]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 12'h001, 1'b1, 12'h002, 1'b1, 1'b0, 12'h001, 1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 12'h001, 1'b1, 12'h002, 1'b0, 1'b1, 12'h002, 1'b1, 1'b0, 16'hA5A4};
        vecs[3]  = '{1'b1, 12'h001, 1'b1, 12'h002, 1'b1, 1'b0, 12'h001, 1'b0, 1'b1, 16'hA5A7};
        vecs[4]  = '{1'b1, 12'h001, 1'b1, 12'h002, 1'b0, 1'b1, 12'h002, 1'b1, 1'b0, 16'hA5A4};
        vecs[5]  = '{1'b1, 12'h001, 1'b1, 12'h002, 1'b1, 1'b0, 12'h001, 1'b0, 1'b1, 16'hA5A7};
        vecs[6]  = '{1'b1, 12'h001, 1'b1, 12'h002, 1'b0, 1'b1, 12'h002, 1'b1, 1'b0, 16'hA5A4};
        vecs[7]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h002, 1'b0, 1'b1, 16'hA5A7};
        vecs[8]  = '{1'b1, 12'h010, 1'b0, 12'h000, 1'b1, 1'b0, 12'h010, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h010, 1'b1, 1'b0, 16'hA5B5};
        vecs[10] = '{1'b0, 12'h000, 1'b1, 12'hFFE, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 12'h000, 1'b1, 12'hFFF, 1'b0, 1'b1, 12'hFFF, 1'b0, 1'b1, 16'hAA5B};
        vecs[12] = '{1'b0, 12'h000, 1'b1, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 16'hAA5A};
        vecs[13] = '{1'b0, 12'h000, 1'b1, 12'h001, 1'b0, 1'b1, 12'h001, 1'b0, 1'b1, 16'hA5A5};
        vecs[14] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h001, 1'b0, 1'b1, 16'hA5A4};
        vecs[15] = '{1'b1, 12'h020, 1'b0, 12'h000, 1'b1, 1'b0, 12'h020, 1'b0, 1'b0, 16'h0000};
        vecs[16] = '{1'b1, 12'h030, 1'b1, 12'h040, 1'b0, 1'b1, 12'h040, 1'b1, 1'b0, 16'hA585};
        vecs[17] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h040, 1'b0, 1'b1, 16'hA5E5};
        vecs[18] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h040, 1'b0, 1'b0, 16'h0000};

        bursts[0] = '{1'b1, 12'h100, 1'b1, 12'h200, 0};
        bursts[1] = '{1'b1, 12'h101, 1'b1, 12'h200, 1};
        bursts[2] = '{1'b1, 12'h101, 1'b0, 12'h000, 0};
        bursts[3] = '{1'b0, 12'h000, 1'b1, 12'h201, 1};
        bursts[4] = '{1'b1, 12'h102, 1'b1, 12'h202, 0};
        bursts[5] = '{1'b1, 12'h103, 1'b1, 12'h202, 1};
        for (int i = 6; i < 10; i++) bursts[i] = '{1'b0, 12'h000, 1'b0, 12'h000, -1};

        // Reset state, with requests asserted to show grants are suppressed
        d1_req0 = 1'b1; d1_req1 = 1'b1; d1_addr0 = 12'h123; d1_addr1 = 12'h456;
        #2;
        check("rst_gnt0", d1_gnt0, 1'b0);
        check("rst_gnt1", d1_gnt1, 1'b0);
        check("rst_rom_en", d1_rom_en, 1'b0);
        check("rst_rom_addr", d1_rom_addr, 12'h000);
        check("rst_rvalid0", d1_rvalid0, 1'b0);
        check("rst_rvalid1", d1_rvalid1, 1'b0);
        d1_req0 = 1'b0; d1_req1 = 1'b0; d1_addr0 = '0; d1_addr1 = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;

        // LAT=1 vector table
        for (int i = 0; i < 19; i++) begin
            @(posedge CLK) #1;
            d1_req0 = vecs[i].req0; d1_addr0 = vecs[i].addr0;
            d1_req1 = vecs[i].req1; d1_addr1 = vecs[i].addr1;
            @(negedge CLK);
            check($sformatf("v%0d_gnt0", i), d1_gnt0, vecs[i].gnt0);
            check($sformatf("v%0d_gnt1", i), d1_gnt1, vecs[i].gnt1);
            check($sformatf("v%0d_rom_en", i), d1_rom_en, vecs[i].gnt0 | vecs[i].gnt1);
            check($sformatf("v%0d_rom_addr", i), d1_rom_addr, vecs[i].rom_addr);
            check($sformatf("v%0d_rvalid0", i), d1_rvalid0, vecs[i].rv0);
            check($sformatf("v%0d_rvalid1", i), d1_rvalid1, vecs[i].rv1);
            if (vecs[i].rv0 || vecs[i].rv1)
                check($sformatf("v%0d_rdata", i), d1_rdata, vecs[i].rdata);
        end

        // LAT=3 interleaved bursts: rvalid exactly 3 cycles after each grant
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK) #1;
            d3_req0 = bursts[k].req0; d3_addr0 = bursts[k].addr0;
            d3_req1 = bursts[k].req1; d3_addr1 = bursts[k].addr1;
            @(negedge CLK);
            check($sformatf("b%0d_gnt0", k), d3_gnt0, bursts[k].gid == 0);
            check($sformatf("b%0d_gnt1", k), d3_gnt1, bursts[k].gid == 1);
            check($sformatf("b%0d_both_rvalid", k), d3_rvalid0 & d3_rvalid1, 1'b0);
            if (k >= 3) begin
                int g;
                logic [11:0] ga;
                g  = bursts[k-3].gid;
                ga = (g == 0) ? bursts[k-3].addr0 : bursts[k-3].addr1;
                check($sformatf("b%0d_rvalid0", k), d3_rvalid0, g == 0);
                check($sformatf("b%0d_rvalid1", k), d3_rvalid1, g == 1);
                if (g >= 0) check($sformatf("b%0d_rdata", k), d3_rdata, rom_word(ga));
            end else begin
                check($sformatf("b%0d_rvalid_early", k), d3_rvalid0 | d3_rvalid1, 1'b0);
            end
        end

        // Mid-operation reset: in-flight reads must never return
        @(posedge CLK) #1;
        d1_req0 = 1'b1; d1_addr0 = 12'h005;
        d3_req0 = 1'b1; d3_addr0 = 12'h005;
        @(negedge CLK);
        check("mr_d1_gnt0", d1_gnt0, 1'b1);
        check("mr_d3_gnt0", d3_gnt0, 1'b1);
        @(posedge CLK) #1;
        d1_req0 = 1'b0; d3_req0 = 1'b0;
        @(negedge CLK);
        check("mr_pre_rvalid0", d1_rvalid0, 1'b1);
        RST = 1'b1;
        d1_req0 = 1'b1; d1_req1 = 1'b1; d3_req0 = 1'b1; d3_req1 = 1'b1;
        #1;
        check("mr_d1_rvalid0_cleared", d1_rvalid0, 1'b0);
        check("mr_d1_gnt", {d1_gnt0, d1_gnt1, d1_rom_en}, 3'b000);
        check("mr_d3_gnt", {d3_gnt0, d3_gnt1, d3_rom_en}, 3'b000);
        check("mr_d1_rom_addr", d1_rom_addr, 12'h000);
        @(posedge CLK) #1;
        check("mr_d1_gnt_held", {d1_gnt0, d1_gnt1}, 2'b00);
        d1_req0 = 1'b0; d1_req1 = 1'b0; d3_req0 = 1'b0; d3_req1 = 1'b0;
        @(negedge CLK) RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check($sformatf("mr_post_d1_rvalid_%0d", i), {d1_rvalid0, d1_rvalid1}, 2'b00);
            check($sformatf("mr_post_d3_rvalid_%0d", i), {d3_rvalid0, d3_rvalid1}, 2'b00);
        end
        @(posedge CLK) #1;
        d1_req0 = 1'b1; d1_addr0 = 12'h007; d1_req1 = 1'b1; d1_addr1 = 12'h008;
        d3_req0 = 1'b1; d3_addr0 = 12'h007; d3_req1 = 1'b1; d3_addr1 = 12'h008;
        @(negedge CLK);
        check("tie_d1_gnt", {d1_gnt0, d1_gnt1}, 2'b10);
        check("tie_d1_rom_addr", d1_rom_addr, 12'h007);
        check("tie_d3_gnt", {d3_gnt0, d3_gnt1}, 2'b10);
        @(posedge CLK) #1;
        d1_req0 = 1'b0; d1_req1 = 1'b0; d3_req0 = 1'b0; d3_req1 = 1'b0;
        repeat (2) @(posedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter AW, default 12, ROM address width.
REQ-002 Parameter DW, default 16, ROM data width.
REQ-003 Parameter LAT, default 1, ROM read latency in cycles from rom_en to valid rom_dout; legal range 1..4.
REQ-004 CLK  in  1  sole clock, all state on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 req0  in  1  requester 0 read request, held until granted.
REQ-007 addr0  in  AW  requester 0 word address, stable while req0 high.
REQ-008 gnt0  out  1  requester 0 request accepted this cycle.
REQ-009 rvalid0  out  1  rdata holds requester 0 read result this cycle.
REQ-010 req1, addr1, gnt1, rvalid1  same widths and meanings for requester 1.
REQ-011 rdata  out  DW  read data shared by both requesters, qualified by rvalid0/rvalid1.
REQ-012 rom_en  out  1  ROM enable to the single-port block ROM.
REQ-013 rom_addr  out  AW  ROM address.
REQ-014 rom_dout  in  DW  ROM read data.

Function
REQ-015 The block SHALL issue at most one ROM read per cycle, granting exactly one requester per issued read.
REQ-016 gnt0/gnt1 SHALL be combinational from req0, req1 and the round-robin pointer; gnt0 and gnt1 never both high.
REQ-017 rom_en SHALL equal gnt0 | gnt1; rom_addr SHALL equal addr0 when gnt0, addr1 when gnt1, and hold the previous rom_addr when no grant.
REQ-018 Single request: the requesting port SHALL be granted in the same cycle.
REQ-019 Simultaneous requests: the port not granted most recently SHALL win; the pointer SHALL update on every grant to the granted port.
REQ-020 A requester holding req continuously SHALL receive a grant at least every second cycle while the other also requests (no starvation).
REQ-021 A requester holding req with no competitor SHALL be granted every cycle (full ROM throughput).
REQ-022 The block SHALL keep a LAT-stage return pipeline of {valid, id}; a grant in cycle N SHALL assert rvalid<id> in cycle N+LAT.
REQ-023 rdata SHALL be rom_dout passed through combinationally; rdata value is don't-care when both rvalids are low.
REQ-024 rvalid0 and rvalid1 SHALL never both be high; return order SHALL equal grant order.
REQ-025 Requests dropped before grant SHALL be discarded without a ROM access or rvalid.
REQ-026 Address wrap: addresses 0 and 2^AW-1 SHALL be passed unmodified; no address arithmetic is performed.

Reset
REQ-027 On RST high, return pipeline valid bits SHALL clear immediately, rvalid0=rvalid1=0, rom_addr=0, pointer = "last granted = 1" (requester 0 wins first tie).
REQ-028 While RST is high, gnt0, gnt1 and rom_en SHALL be 0 regardless of requests.
REQ-029 Reads granted before a mid-operation reset SHALL never produce rvalid after reset deasserts.
REQ-030 The first tie after reset release SHALL be granted to requester 0.

Structure
REQ-031 AW, DW defaults and the LAT legal range SHALL live in a shared package (mp3_mem_pkg) with the block ROM geometry (4096 x 16).
REQ-032 The return pipeline SHALL be one sub-module, rom_ret_pipe (parameter LAT, 2-bit payload {valid,id}, async clear).
REQ-033 The block SHALL instantiate no ROM; it connects to the existing blk_mem_gen_0 via rom_en/rom_addr/rom_dout with the ROM ena driven by rom_en.

Verification (LAT=1, ROM preloaded mem[a]=a^16'hA5A5 unless noted)
REQ-034 req0=1 addr0=12'h010 one cycle, req1=0 -> gnt0 same cycle, rom_addr=12'h010, next cycle rvalid0=1 rdata=16'hA5B5.
REQ-035 req0=req1=1 held 6 cycles, addr0=1, addr1=2, after reset -> grants 0,1,0,1,0,1; rvalids alternate one cycle later with rdata A5A4/A5A7.
REQ-036 req1 alone held 4 cycles, addresses 12'hFFE,12'hFFF,12'h000,12'h001 -> gnt1 every cycle, four consecutive rvalid1 with matching data, no rvalid0.
REQ-037 LAT=3 rebuild, interleaved bursts -> each rvalid exactly 3 cycles after its grant, order preserved, never both rvalids high.
REQ-038 Grant at cycle N, RST pulsed high mid-cycle N+0.5 -> rvalid0/rvalid1 low immediately and stay low after release; next tie grants requester 0.
REQ-039 req0 raised then dropped in a cycle where req1 wins -> no later gnt0, no rvalid0, rom_en only for requester 1.
